// File: rtl/shift_defs.sv
`default_nettype none
// shift_defs: operation and FSM state encodings shared by the iterative shifter.
package shift_defs;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    SHIFT = ST_SHIFT_ENC,
    DONE  = ST_DONE_ENC
  } state_e;

endpackage
`default_nettype wire

// File: rtl/iter_shifter_shift_step.sv
`default_nettype none
// shift_step: combinational single-bit shift/rotate of a value by the selected op.
module shift_step
  import shift_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    value_o = value_i;
    case (op_i)
      OP_SLL:  value_o = {value_i[WIDTH-2:0], 1'b0};
      OP_SRL:  value_o = {1'b0, value_i[WIDTH-1:1]};
      OP_SRA:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
      OP_ROR:  value_o = {value_i[0], value_i[WIDTH-1:1]};
      default: value_o = value_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// iter_shifter: multi-cycle barrel-shift replacement that applies one bit
// of shift per clock until the latched shift amount is exhausted.
module iter_shifter
  import shift_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] step_value;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_shift_step (
    .op_i    (op_q),
    .value_i (res_q),
    .value_o (step_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // SHIFT is only entered with a non-zero count, so the counter cannot wrap.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          res_d   = data_in;
          op_d    = op;
          cnt_d   = shamt;
          state_d = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        res_d = step_value;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign data_out = res_q;
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// tb_iter_shifter: directed and random checks of iter_shifter against an arithmetic model.
module tb_iter_shifter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  iter_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt    (shamt),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] model(input logic [1:0] o, input int s, input logic [31:0] d);
    logic [31:0] r;
    case (o)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = 32'($signed(d) >>> s);
      default: r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches one operation, optionally pulses a second start mid-shift,
  // and checks latency, busy duration, result and the single done pulse.
  task automatic run(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                     input bit poke, input logic [1:0] po, input logic [4:0] ps,
                     input logic [31:0] pd);
    int lat;
    int busy_cnt;
    logic [31:0] exp;
    exp = model(o, int'(s), d);
    @(negedge clk);
    start = 1'b1; op = o; shamt = s; data_in = d;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 64) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      start = 1'b0;
      if (poke && lat == 2) begin
        start = 1'b1; op = po; shamt = ps; data_in = pd;
      end
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(int'(s) + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(s));
    check("result", data_out, exp);
    check("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    op = 2'($urandom); shamt = 5'($urandom); data_in = $urandom;
    @(negedge clk);
    @(negedge clk);
    check("no_extra_done", 32'(done), 32'd0);
    check("result_hold", data_out, exp);
  endtask

  initial begin
    int seen_done;
    reset = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; data_in = 32'h0;
    #1;
    check("reset_data", data_out, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run(2'b00, 5'd4,  32'h0000_0001, 1'b0, 2'b00, 5'd0, 32'h0);
    run(2'b10, 5'd31, 32'h8000_0000, 1'b0, 2'b00, 5'd0, 32'h0);
    run(2'b01, 5'd31, 32'h8000_0000, 1'b0, 2'b00, 5'd0, 32'h0);
    run(2'b11, 5'd1,  32'h0000_0001, 1'b0, 2'b00, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      run(2'(k), 5'd0, 32'hDEAD_BEEF, 1'b0, 2'b00, 5'd0, 32'h0);
    end
    run(2'b00, 5'd8, 32'h0000_0001, 1'b1, 2'b01, 5'd2, 32'hFFFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      run(2'($urandom), 5'($urandom), $urandom, bit'($urandom), 2'($urandom),
          5'($urandom), $urandom);
    end

    // Abort an SLL by 10 with reset in its third cycle.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = 5'd10; data_in = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_data", data_out, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run(2'b00, 5'd1, 32'h0000_0003, 1'b0, 2'b00, 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
